// File: rtl/param_cache_controller.sv
// N-way set-associative write-through, no-write-allocate data cache with true-LRU replacement.
// Optional hit/miss statistics outputs are enabled by defining CACHE_STATS_EN.
module param_cache_controller #(
  parameter int WAYS       = 2,
  parameter int SETS       = 64,
  parameter int LINE_WORDS = 2,
  parameter int BASE_ADDR  = 1024
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [31:0]             address,
  input  logic [31:0]             wdata,
  input  logic                    MEM_R_EN,
  input  logic                    MEM_W_EN,
  output logic [31:0]             rdata,
  output logic                    ready,
  output logic [31:0]             sram_address,
  output logic [31:0]             sram_wdata,
  output logic                    write,
  output logic                    read,
  input  logic [32*LINE_WORDS-1:0] sram_rdata,
  input  logic                    sram_ready
`ifdef CACHE_STATS_EN
  ,
  output logic [31:0]             hit_count,
  output logic [31:0]             miss_count
`endif
);

  localparam int OFF_B  = $clog2(LINE_WORDS);
  localparam int SET_B  = $clog2(SETS);
  localparam int TAG_W  = 30 - OFF_B - SET_B;
  localparam int WORD_W = (LINE_WORDS > 1) ? OFF_B : 1;
  localparam int WAY_W  = (WAYS > 1) ? $clog2(WAYS) : 1;
  localparam int AGE_W  = WAY_W;
  localparam logic [31:0] LINE_MASK = 32'(LINE_WORDS * 4 - 1);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_RMISS = 2'd1;
  localparam logic [1:0] ST_WRITE = 2'd2;

  logic [1:0]       state_r;
  logic [1:0]       state_nxt_s;
  logic [SETS-1:0]  valid_r [WAYS];
  logic [TAG_W-1:0] tag_r   [WAYS][SETS];
  logic [31:0]      data_r  [WAYS][SETS][LINE_WORDS];
  logic [AGE_W-1:0] age_cur_s [WAYS];

  logic [31:0]       eff_s;
  logic [TAG_W-1:0]  tag_s;
  logic [SET_B-1:0]  set_s;
  logic [WORD_W-1:0] word_s;

  logic             hit_s;
  logic [WAY_W-1:0] hit_way_s;
  logic [WAY_W-1:0] vict_way_s;
  logic             lru_en_s;
  logic [WAY_W-1:0] lru_way_s;
  logic             fill_s;
  logic             wupd_s;
  logic             miss_start_s;
  logic             rd_hit_s;

  assign eff_s = address - 32'(BASE_ADDR);
  assign tag_s = eff_s[31 -: TAG_W];
  assign set_s = eff_s[2 + OFF_B +: SET_B];

  if (LINE_WORDS > 1) begin : g_word
    assign word_s = eff_s[2 +: OFF_B];
  end else begin : g_one_word
    assign word_s = 1'b0;
  end

  // Tag compare across all ways of the addressed set
  always_comb begin
    hit_s     = 1'b0;
    hit_way_s = '0;
    for (int w = 0; w < WAYS; w++) begin
      hit_way_s = (valid_r[w][set_s] && (tag_r[w][set_s] == tag_s) && !hit_s) ? WAY_W'(w) : hit_way_s;
      hit_s     = hit_s | (valid_r[w][set_s] && (tag_r[w][set_s] == tag_s));
    end
  end

  // Victim choice: lowest invalid way, otherwise the oldest way
  always_comb begin
    logic found;
    found      = 1'b0;
    vict_way_s = '0;
    for (int w = 0; w < WAYS; w++) begin
      vict_way_s = (!valid_r[w][set_s] && !found) ? WAY_W'(w) : vict_way_s;
      found      = found | !valid_r[w][set_s];
    end
    for (int w = 0; w < WAYS; w++) begin
      vict_way_s = (!found && (age_cur_s[w] == AGE_W'(WAYS - 1))) ? WAY_W'(w) : vict_way_s;
    end
  end

  // Next-state and cache update strobes
  always_comb begin
    state_nxt_s  = state_r;
    lru_en_s     = 1'b0;
    lru_way_s    = hit_way_s;
    fill_s       = 1'b0;
    wupd_s       = 1'b0;
    miss_start_s = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (MEM_W_EN) begin
          state_nxt_s = ST_WRITE;
        end else if (MEM_R_EN) begin
          if (hit_s) begin
            lru_en_s = 1'b1;
          end else begin
            state_nxt_s  = ST_RMISS;
            miss_start_s = 1'b1;
          end
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_RMISS: begin
        if (sram_ready) begin
          fill_s      = 1'b1;
          lru_en_s    = 1'b1;
          lru_way_s   = vict_way_s;
          state_nxt_s = ST_IDLE;
        end else begin
          state_nxt_s = ST_RMISS;
        end
      end
      ST_WRITE: begin
        if (sram_ready) begin
          wupd_s      = hit_s;
          lru_en_s    = hit_s;
          state_nxt_s = ST_IDLE;
        end else begin
          state_nxt_s = ST_WRITE;
        end
      end
      default: begin
        state_nxt_s = ST_IDLE;
      end
    endcase
  end

  assign rd_hit_s = (state_r == ST_IDLE) && MEM_R_EN && !MEM_W_EN && hit_s;

  // State and valid bits; reset aborts any outstanding access
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r <= ST_IDLE;
      for (int w = 0; w < WAYS; w++) begin
        valid_r[w] <= '0;
      end
    end else begin
      state_r <= state_nxt_s;
      if (fill_s) begin
        valid_r[vict_way_s][set_s] <= 1'b1;
      end
    end
  end

  // Tag and data arrays need no reset; valid bits gate their use
  always_ff @(posedge clk) begin
    if (fill_s) begin
      tag_r[vict_way_s][set_s] <= tag_s;
      for (int k = 0; k < LINE_WORDS; k++) begin
        data_r[vict_way_s][set_s][k] <= sram_rdata[32*k +: 32];
      end
    end
    if (wupd_s) begin
      data_r[hit_way_s][set_s][word_s] <= wdata;
    end
  end

  if (WAYS > 1) begin : g_lru
    logic [AGE_W-1:0] age_r [WAYS][SETS];

    // Current ages of the addressed set
    always_comb begin
      for (int j = 0; j < WAYS; j++) begin
        age_cur_s[j] = age_r[j][set_s];
      end
    end

    // True-LRU ages: accessed way becomes 0, younger ways age by one
    always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
        for (int j = 0; j < WAYS; j++) begin
          for (int s = 0; s < SETS; s++) begin
            age_r[j][s] <= AGE_W'(j);
          end
        end
      end else if (lru_en_s) begin
        for (int j = 0; j < WAYS; j++) begin
          if (WAY_W'(j) == lru_way_s) begin
            age_r[j][set_s] <= '0;
          end else if (age_r[j][set_s] < age_r[lru_way_s][set_s]) begin
            age_r[j][set_s] <= age_r[j][set_s] + AGE_W'(1);
          end
        end
      end
    end
  end else begin : g_no_lru
    assign age_cur_s[0] = '0;
  end

  // Requester and SRAM-side outputs; reset forces the idle handshake
  always_comb begin
    ready        = 1'b1;
    rdata        = 32'd0;
    read         = 1'b0;
    write        = 1'b0;
    sram_address = 32'd0;
    sram_wdata   = 32'd0;
    case (state_r)
      ST_IDLE: begin
        if (MEM_W_EN) begin
          ready = 1'b0;
        end else if (MEM_R_EN) begin
          ready = hit_s;
          rdata = hit_s ? data_r[hit_way_s][set_s][word_s] : 32'd0;
        end else begin
          ready = 1'b1;
        end
      end
      ST_RMISS: begin
        read         = 1'b1;
        sram_address = eff_s & ~LINE_MASK;
        ready        = sram_ready;
        rdata        = sram_ready ? sram_rdata[32*word_s +: 32] : 32'd0;
      end
      ST_WRITE: begin
        write        = 1'b1;
        sram_address = eff_s;
        sram_wdata   = wdata;
        ready        = sram_ready;
      end
      default: begin
        ready = 1'b1;
      end
    endcase
    if (!rst) begin
      ready        = 1'b1;
      rdata        = 32'd0;
      read         = 1'b0;
      write        = 1'b0;
      sram_address = 32'd0;
      sram_wdata   = 32'd0;
    end else begin
      ready = ready;
    end
  end

`ifdef CACHE_STATS_EN
  // Read-hit and miss-entry counters, wrapping at 2^32
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      hit_count  <= 32'd0;
      miss_count <= 32'd0;
    end else begin
      if (rd_hit_s) begin
        hit_count <= hit_count + 32'd1;
      end
      if (miss_start_s) begin
        miss_count <= miss_count + 32'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_param_cache_controller.sv
// Self-checking bench for param_cache_controller: directed scenarios plus random traffic
// compared against a recency-list cache model backed by a sparse memory model.
module tb_param_cache_controller;
  localparam int W  = 2;
  localparam int S  = 64;
  localparam int LW = 2;

  logic        clk;
  logic        rst;
  logic [31:0] address;
  logic [31:0] wdata;
  logic        MEM_R_EN;
  logic        MEM_W_EN;
  logic [31:0] rdata;
  logic        ready;
  logic [31:0] sram_address;
  logic [31:0] sram_wdata;
  logic        write;
  logic        read;
  logic [63:0] sram_rdata;
  logic        sram_ready;
`ifdef CACHE_STATS_EN
  logic [31:0] hit_count;
  logic [31:0] miss_count;
`endif

  param_cache_controller #(.WAYS(W), .SETS(S), .LINE_WORDS(LW), .BASE_ADDR(1024)) dut (
    .clk          (clk),
    .rst          (rst),
    .address      (address),
    .wdata        (wdata),
    .MEM_R_EN     (MEM_R_EN),
    .MEM_W_EN     (MEM_W_EN),
    .rdata        (rdata),
    .ready        (ready),
    .sram_address (sram_address),
    .sram_wdata   (sram_wdata),
    .write        (write),
    .read         (read),
    .sram_rdata   (sram_rdata),
    .sram_ready   (sram_ready)
`ifdef CACHE_STATS_EN
    ,
    .hit_count    (hit_count),
    .miss_count   (miss_count)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model: per-set lines plus a recency list (index 0 = most recent)
  bit          mvalid [W][S];
  logic [31:0] mtag   [W][S];
  logic [31:0] mdata  [W][S][LW];
  int          order  [S][W];
  logic [31:0] mem [logic [31:0]];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] memrd(input logic [31:0] wa);
    if (!mem.exists(wa)) mem[wa] = $urandom;
    return mem[wa];
  endfunction

  function automatic void model_reset();
    for (int s = 0; s < S; s++)
      for (int w = 0; w < W; w++) begin
        mvalid[w][s] = 1'b0;
        order[s][w]  = w;
      end
  endfunction

  function automatic int find_way(input int s, input logic [31:0] t);
    for (int w = 0; w < W; w++)
      if (mvalid[w][s] && mtag[w][s] == t) return w;
    return -1;
  endfunction

  function automatic int victim(input int s);
    for (int w = 0; w < W; w++)
      if (!mvalid[w][s]) return w;
    return order[s][W-1];
  endfunction

  function automatic void touch(input int s, input int way);
    int p;
    p = 0;
    for (int i = 0; i < W; i++)
      if (order[s][i] == way) p = i;
    for (int i = p; i > 0; i--) order[s][i] = order[s][i-1];
    order[s][0] = way;
  endfunction

  // One requester transaction with SRAM responder of the given latency (>= 1)
  task automatic access(input bit rd, input bit wr, input logic [31:0] addr,
                        input logic [31:0] wd, input int lat);
    logic [31:0] eff, tg, lbase, exp_word;
    int wrd, st, way, v;
    eff   = addr - 32'd1024;
    wrd   = int'((eff >> 2) % LW);
    st    = int'((eff >> 3) % S);
    tg    = eff >> 9;
    lbase = eff & ~32'd7;
    way   = find_way(st, tg);
    @(negedge clk);
    address = addr; wdata = wd; MEM_R_EN = rd; MEM_W_EN = wr;
    sram_ready = 1'b0; sram_rdata = {$urandom, $urandom};
    if (rd && !wr && way >= 0) begin
      #1;
      check("hit_ready", 32'(ready), 32'd1);
      check("hit_rdata", rdata, mdata[way][st][wrd]);
      check("hit_read", 32'(read), 32'd0);
      touch(st, way);
      @(posedge clk);
    end else if (rd || wr) begin
      for (int c = 0; c <= lat; c++) begin
        if (c > 0) @(negedge clk);
        if (c == lat) begin
          sram_ready = 1'b1;
          sram_rdata = {memrd((lbase >> 2) + 32'd1), memrd(lbase >> 2)};
        end
        #1;
        check("ready_wait", 32'(ready), (c == lat) ? 32'd1 : 32'd0);
        if (c > 0 && wr) begin
          check("write_strobe", 32'(write), 32'd1);
          check("write_noread", 32'(read), 32'd0);
          check("write_addr", sram_address, eff);
          check("write_data", sram_wdata, wd);
        end else if (c > 0) begin
          check("read_strobe", 32'(read), 32'd1);
          check("read_nowrite", 32'(write), 32'd0);
          check("read_addr", sram_address, lbase);
        end
        if (!wr && c == lat) begin
          exp_word = memrd((eff >> 2));
          check("miss_rdata", rdata, exp_word);
        end
        @(posedge clk);
      end
      if (wr) begin
        mem[eff >> 2] = wd;
        if (way >= 0) begin
          mdata[way][st][wrd] = wd;
          touch(st, way);
        end
      end else begin
        v = victim(st);
        mvalid[v][st] = 1'b1;
        mtag[v][st]   = tg;
        for (int k = 0; k < LW; k++) mdata[v][st][k] = memrd((lbase >> 2) + 32'(k));
        touch(st, v);
      end
    end
    @(negedge clk);
    MEM_R_EN = 1'b0; MEM_W_EN = 1'b0; sram_ready = 1'b0;
    #1;
    check("idle_read", 32'(read), 32'd0);
    check("idle_write", 32'(write), 32'd0);
    check("idle_ready", 32'(ready), 32'd1);
  endtask

  initial begin
    logic [31:0] a_addr, b_addr, c_addr, rnd_addr;
`ifdef CACHE_STATS_EN
    logic [31:0] h0, m0;
`endif
    int op;
    rst = 1'b0; address = 32'd1024; wdata = 32'd0; MEM_R_EN = 1'b1; MEM_W_EN = 1'b0;
    sram_rdata = 64'd0; sram_ready = 1'b0;
    model_reset();
    repeat (2) @(negedge clk);
    #1;
    check("rst_ready", 32'(ready), 32'd1);
    check("rst_rdata", rdata, 32'd0);
    check("rst_read", 32'(read), 32'd0);
    check("rst_write", 32'(write), 32'd0);
`ifdef CACHE_STATS_EN
    check("rst_hits", hit_count, 32'd0);
    check("rst_misses", miss_count, 32'd0);
`endif
    MEM_R_EN = 1'b0;
    @(negedge clk);
    rst = 1'b1;

    // Cold load, hit on the other word, store hit, reload of stored word
    access(1'b1, 1'b0, 32'd1024, 32'd0, 4);
    access(1'b1, 1'b0, 32'd1028, 32'd0, 4);
    access(1'b0, 1'b1, 32'd1028, 32'hDEADBEEF, 3);
    access(1'b1, 1'b0, 32'd1028, 32'd0, 2);
    check("store_hit_value", mdata[find_way(0, 32'd0)][0][1], 32'hDEADBEEF);

    // Store miss, then load of the same address must fetch
    access(1'b0, 1'b1, 32'd2048, 32'h12345678, 2);
    access(1'b1, 1'b0, 32'd2048, 32'd0, 3);

    // LRU in set 5: A, B, A, C (evicts B), A hits, B misses
    a_addr = 32'd1024 + 32'd40;
    b_addr = a_addr + 32'd512;
    c_addr = a_addr + 32'd1024;
`ifdef CACHE_STATS_EN
    h0 = hit_count; m0 = miss_count;
`endif
    access(1'b1, 1'b0, a_addr, 32'd0, 2);
    access(1'b1, 1'b0, b_addr, 32'd0, 2);
    access(1'b1, 1'b0, a_addr, 32'd0, 2);
    access(1'b1, 1'b0, c_addr, 32'd0, 2);
`ifdef CACHE_STATS_EN
    check("lru_hits", hit_count - h0, 32'd1);
    check("lru_misses", miss_count - m0, 32'd3);
`endif
    check("lru_b_evicted", 32'(find_way(5, b_addr - 32'd1024 >> 9)), 32'hFFFFFFFF);
    access(1'b1, 1'b0, a_addr, 32'd0, 1);
    access(1'b1, 1'b0, b_addr, 32'd0, 3);

    // Both enables: treated as a store, no fill
    access(1'b1, 1'b1, 32'd1024, 32'd5, 2);
    access(1'b1, 1'b1, 32'd1024 + 32'd56, 32'd7, 2);
    access(1'b1, 1'b0, 32'd1024 + 32'd56, 32'd0, 2);
    access(1'b1, 1'b0, 32'd1024, 32'd0, 1);

    // Random traffic over 4 sets x 4 tags to exercise evictions
    for (int i = 0; i < 80; i++) begin
      rnd_addr = 32'd1024 + 32'($urandom_range(0, 3)) * 32'd512
               + 32'($urandom_range(0, 3)) * 32'd8 + 32'($urandom_range(0, 1)) * 32'd4;
      op = int'($urandom_range(0, 9));
      access((op < 7) || (op == 9), (op >= 7), rnd_addr, $urandom, int'($urandom_range(1, 4)));
    end

    // Reset in the middle of a read miss
    access(1'b1, 1'b0, 32'd1024, 32'd0, 1);
    @(negedge clk);
    address = 32'd1024 + 32'd160; MEM_R_EN = 1'b1;
    @(negedge clk);
    #1;
    check("pre_abort_read", 32'(read), 32'd1);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("abort_read", 32'(read), 32'd0);
    check("abort_ready", 32'(ready), 32'd1);
    check("abort_rdata", rdata, 32'd0);
    MEM_R_EN = 1'b0;
    model_reset();
    @(negedge clk);
    rst = 1'b1;
    access(1'b1, 1'b0, 32'd1024, 32'd0, 2);
    access(1'b1, 1'b0, 32'd1028, 32'd0, 2);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule
